dcache_d0_sched_stage: RTL and testbench
========================================

// Module: dcache_d0_sched_stage
// PURPOSE
// - Parametrised d0 front-end for the L1 D-Cache: N_CH valid/ready request channels, fixed-priority pick.
// - Issues a one-hot grant to the cache controller in the same cycle, and drives the tag/data SRAM
//   address/control from it.
// - Result goes into a d0->d1 output register with a valid/ready handshake.
// - Generalises the rst/d1/L2/upd/LSQ scheduler+arbiter to any channel count.
// - Adds a stall pass mask, write-only (non-forwarding) channels and optional anti-starvation aging.
// PARAMETERS
// - N_CH             5    number of request channels; ch 0 = highest priority
// - DATA_W           128  per-channel request payload width (packed info forwarded to d1)
// - FWD_MASK         5'b11110  bit c=1: grant of ch c loads the d1 output reg; 0: SRAM-only (e.g. reset sweep)
// - STALL_PASS_MASK  5'b00100  bit c=1: ch c may still win while stall_i=1 (e.g. L2 answers)
// - MAX_WAIT         15   lost-arbitration cycles before a channel becomes urgent (STARVE_EN only)
// - WAIT_W           $clog2(MAX_WAIT+1)  aging counter width
// PORTS
// - clk_i        in   1              clock
// - rst_ni       in   1              asynchronous active-low reset
// - clr_i        in   1              synchronous clear: empties output reg and aging counters
// - stall_i      in   1              d1 stalled; only STALL_PASS_MASK channels are eligible
// - req_valid_i  in   N_CH           per-channel request valid
// - req_data_i   in   N_CH*DATA_W    per-channel payload, ch c at [c*DATA_W +: DATA_W]
// - req_ready_o  out  N_CH           per-channel accept; equals grant_o
// - grant_o      out  N_CH           one-hot winner this cycle (0 if none); drives cache ctrl/SRAM enables
// - out_valid_o  out  1              d1 output register holds a request
// - out_data_o   out  DATA_W         registered payload of the forwarded request
// - out_ch_o     out  $clog2(N_CH)   source channel of out_data_o
// - out_ready_i  in   1              d1 accepts the registered request this cycle
// BEHAVIOUR
// - Reset (rst_ni=0, async): out_valid_o=0, out_data_o=0, out_ch_o=0, all aging counters=0.
//   Combinational outputs grant_o/req_ready_o follow inputs; they are 0 while no request is valid.
// - Eligibility: elig[c] = req_valid_i[c] & (~stall_i | STALL_PASS_MASK[c]) & (~FWD_MASK[c] | reg_free).
//   reg_free = ~out_valid_o | out_ready_i.
// - Pick: lowest-index eligible channel (fixed priority). grant_o is one-hot or zero.
//   A request is accepted in the cycle when req_valid & req_ready are both 1.
//   No combinational path from req_valid_i[c] to req_ready_o[c] other than through the pick.
// - Output reg, priority order: clr_i -> empty.
//   Else a granted FWD channel loads {data,ch} and sets out_valid_o=1 on the next edge (1-cycle latency).
//   Else if out_ready_i -> out_valid_o=0.
//   Else hold: data and ch stable while valid & ~ready.
// - Simultaneous out_ready_i=1 and a new FWD grant: back-to-back streaming, with no bubble.
// - A non-FWD grant never touches the output reg. While the reg is full and d1 is not ready,
//   a non-FWD grant still proceeds (SRAM-only work overlaps the stall).
// - stall_i=1 with only masked channels valid: grant_o=0 and all req_ready_o=0.
//   Requests hold their valid (requesters must not drop valid before acceptance).
// - clr_i=1 blocks no grant this cycle. The accepted request's reg load is discarded by the clear,
//   so requesters must not present requests during clr_i.
// - Reset mid-operation: registered request lost. Requesters re-issue after reset.
// CONFIGURATION
// - Macro D0_SCHED_STARVE_EN.
// - Defined: per-channel wait counter.
//   - +1 (saturating at MAX_WAIT) when elig[c]=1 and grant_o[c]=0.
//   - Cleared on grant or when req_valid_i[c]=0.
//   - urgent[c] = (cnt==MAX_WAIT). If any eligible channel is urgent, the pick is the lowest-index
//     urgent eligible channel. Otherwise plain fixed priority.
//   - Bound: any eligible channel is granted within MAX_WAIT+N_CH cycles.
// - Undefined: no counters, pure fixed priority; MAX_WAIT/WAIT_W unused. A low channel can starve.
// TESTING
// - Reset: rst_ni=0 with req_valid_i=5'b11111 -> out_valid_o=0; after release with out_ready_i=1,
//   grant_o=5'b00001 (ch 0 non-FWD), no output load.
// - Priority+latency: valid=5'b10010, out_ready_i=1 -> grant_o=5'b00010;
//   next cycle out_valid_o=1, out_ch_o=1, out_data_o=ch1 payload.
// - Backpressure: reg full, out_ready_i=0, valid=5'b00011 -> grant_o=5'b00001 (non-FWD passes),
//   ch1 ready=0, out_data_o stable over 4 cycles.
// - Stall: stall_i=1, valid=5'b11010 -> grant_o=0; add ch2 valid -> grant_o=5'b00100, loads reg.
// - Streaming: out_ready_i=1, ch4 valid continuously, others idle -> one grant per cycle, out_valid_o
//   held 1, payload updates every edge.
// - STARVE_EN: ch1 and ch4 valid for 40 cycles, out_ready_i=1 -> ch4 granted exactly at cycle 16
//   (MAX_WAIT=15 lost cycles), then counter=0. Without the macro, ch4 is never granted.

Source files
------------

// File: rtl/dcache_d0_sched_stage.sv
// L1 D-cache d0 front-end: fixed-priority pick over N_CH valid/ready channels, one-hot grant to
// the cache controller/SRAM, and a d0->d1 output register. `define D0_SCHED_STARVE_EN adds aging.
module dcache_d0_sched_stage #(
    parameter int unsigned        N_CH            = 5,
    parameter int unsigned        DATA_W          = 128,
    parameter logic [N_CH-1:0]    FWD_MASK        = 5'b11110,
    parameter logic [N_CH-1:0]    STALL_PASS_MASK = 5'b00100,
    parameter int unsigned        MAX_WAIT        = 15,
    parameter int unsigned        WAIT_W          = $clog2(MAX_WAIT + 1),
    parameter int unsigned        CH_W            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   stall_i,
    input  logic [N_CH-1:0]        req_valid_i,
    input  logic [N_CH*DATA_W-1:0] req_data_i,
    output logic [N_CH-1:0]        req_ready_o,
    output logic [N_CH-1:0]        grant_o,
    output logic                   out_valid_o,
    output logic [DATA_W-1:0]      out_data_o,
    output logic [CH_W-1:0]        out_ch_o,
    input  logic                   out_ready_i
);

    // An undersized WAIT_W override would make the urgent state unreachable.
    if (WAIT_W < $clog2(MAX_WAIT + 1)) begin : g_wait_w_too_small
        $error("WAIT_W too small to hold MAX_WAIT");
    end

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [CH_W-1:0]     r_out_ch;

    logic                w_reg_free;
    logic [N_CH-1:0]     w_elig;
    logic [N_CH-1:0]     w_cand;
    logic [N_CH-1:0]     w_grant;
    logic [CH_W-1:0]     w_grant_ch;
    logic [DATA_W-1:0]   w_grant_data;
    logic                w_fwd_load;

    assign w_reg_free = ~r_out_valid | out_ready_i;

    // A forwarding channel is only eligible when the d1 register can take it this edge.
    always_comb begin
        w_elig = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_elig[c] = req_valid_i[c]
                      & (~stall_i | STALL_PASS_MASK[c])
                      & (~FWD_MASK[c] | w_reg_free);
        end
    end

`ifdef D0_SCHED_STARVE_EN
    logic [WAIT_W-1:0] r_wait [N_CH];
    logic [N_CH-1:0]   w_urgent;

    always_comb begin
        w_urgent = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_urgent[c] = w_elig[c] & (r_wait[c] == WAIT_W'(MAX_WAIT));
        end
    end

    assign w_cand = (|w_urgent) ? w_urgent : w_elig;

    // Counters only age while the channel competes and loses; a blocked channel just holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < N_CH; c++) begin
                r_wait[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (clr_i || !req_valid_i[c] || w_grant[c]) begin
                    r_wait[c] <= '0;
                end else if (w_elig[c] && (r_wait[c] != WAIT_W'(MAX_WAIT))) begin
                    r_wait[c] <= r_wait[c] + 1'b1;
                end
            end
        end
    end
`else
    assign w_cand = w_elig;
`endif

    // Scan from the top down so the lowest-index candidate is the last one written.
    always_comb begin
        w_grant      = '0;
        w_grant_ch   = '0;
        w_grant_data = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (w_cand[c]) begin
                w_grant      = '0;
                w_grant[c]   = 1'b1;
                w_grant_ch   = CH_W'(c);
                w_grant_data = req_data_i[c*DATA_W +: DATA_W];
            end
        end
    end

    assign w_fwd_load  = |(w_grant & FWD_MASK);
    assign grant_o     = w_grant;
    assign req_ready_o = w_grant;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (clr_i) begin
            r_out_valid <= 1'b0;
        end else if (w_fwd_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_ch    <= w_grant_ch;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_ch_o    = r_out_ch;

endmodule

// File: tb/tb_dcache_d0_sched_stage.sv
// Randomized and directed bench for dcache_d0_sched_stage against a cycle-level behavioural model.
module tb_dcache_d0_sched_stage;

    localparam int N_CH     = 5;
    localparam int DATA_W   = 128;
    localparam int CH_W     = 3;
    localparam int MAX_WAIT = 15;
    localparam logic [4:0] FWD  = 5'b11110;
    localparam logic [4:0] PASS = 5'b00100;
`ifdef D0_SCHED_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   clr = 1'b0;
    logic                   stall = 1'b0;
    logic                   out_ready = 1'b0;
    logic [N_CH-1:0]        req_valid = '0;
    logic [N_CH*DATA_W-1:0] req_data = '0;
    logic [N_CH-1:0]        req_ready;
    logic [N_CH-1:0]        grant;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [CH_W-1:0]        out_ch;

    dcache_d0_sched_stage dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr),
        .stall_i     (stall),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .grant_o     (grant),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ch_o    (out_ch),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: what d1 should see, and how long each requester has been losing.
    bit           m_valid;
    logic [127:0] m_data;
    int           m_ch;
    int           m_wait [N_CH];
    logic [4:0]   last_grant;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_elig(input int c);
        bit free;
        free = !m_valid || out_ready;
        return req_valid[c] && (!stall || PASS[c]) && (!FWD[c] || free);
    endfunction

    function automatic int ref_pick();
        int first;
        int first_urg;
        first = -1;
        first_urg = -1;
        for (int c = 0; c < N_CH; c++) begin
            if (ref_elig(c)) begin
                if (first < 0) first = c;
                if (STARVE && m_wait[c] >= MAX_WAIT && first_urg < 0) first_urg = c;
            end
        end
        return (first_urg >= 0) ? first_urg : first;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        for (int c = 0; c < N_CH; c++) m_wait[c] = 0;
    endtask

    // One clock cycle: drive at the falling edge, check 1ns later, advance the model, wait a cycle.
    task automatic step(input string tag, input logic [4:0] v, input bit st, input bit rdy, input bit cl);
        int         w;
        logic [4:0] eg;
        bit         el [N_CH];
        req_valid = v;
        stall     = st;
        out_ready = rdy;
        clr       = cl;
        for (int i = 0; i < N_CH * DATA_W / 32; i++) req_data[i*32 +: 32] = $urandom;
        #1;
        w  = ref_pick();
        eg = (w >= 0) ? (5'b00001 << w) : 5'b00000;
        chk({tag, ".grant"}, 128'(grant), 128'(eg));
        chk({tag, ".ready"}, 128'(req_ready), 128'(eg));
        chk({tag, ".out_valid"}, 128'(out_valid), 128'(m_valid));
        if (m_valid) begin
            chk({tag, ".out_data"}, out_data, m_data);
            chk({tag, ".out_ch"}, 128'(out_ch), 128'(m_ch));
        end
        last_grant = grant;
        for (int c = 0; c < N_CH; c++) el[c] = ref_elig(c);
        for (int c = 0; c < N_CH; c++) begin
            if (cl || !v[c] || w == c) m_wait[c] = 0;
            else if (el[c] && m_wait[c] < MAX_WAIT) m_wait[c]++;
        end
        if (cl) begin
            m_valid = 1'b0;
        end else if (w >= 0 && FWD[w]) begin
            m_valid = 1'b1;
            m_data  = req_data[w*DATA_W +: DATA_W];
            m_ch    = w;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int first4;
        int n4;
        logic [127:0] held;

        model_reset();
        rst_n     = 1'b0;
        req_valid = 5'b11111;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.out_valid", 128'(out_valid), 128'(0));
        chk("rst.out_data", out_data, 128'(0));
        chk("rst.out_ch", 128'(out_ch), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // ch0 is SRAM-only: granted first, nothing reaches d1
        step("rst_rel", 5'b11111, 1'b0, 1'b1, 1'b0);
        step("rst_rel2", 5'b00000, 1'b0, 1'b1, 1'b0);

        step("prio", 5'b10010, 1'b0, 1'b1, 1'b0);
        chk("prio.grant_ch1", 128'(last_grant), 128'(5'b00010));
        step("prio_out", 5'b00000, 1'b0, 1'b1, 1'b0);

        step("bp_fill", 5'b00010, 1'b0, 1'b1, 1'b0);
        held = out_data;
        for (int i = 0; i < 4; i++) begin
            step("bp", 5'b00011, 1'b0, 1'b0, 1'b0);
            chk("bp.grant_ch0", 128'(last_grant), 128'(5'b00001));
            chk("bp.stable", out_data, m_data);
        end
        chk("bp.loaded_changed", 128'(out_ch), 128'(1));
        step("bp_drain", 5'b00000, 1'b0, 1'b1, 1'b0);

        step("stall", 5'b11010, 1'b1, 1'b1, 1'b0);
        chk("stall.none", 128'(last_grant), 128'(0));
        step("stall_pass", 5'b11110, 1'b1, 1'b1, 1'b0);
        chk("stall.ch2", 128'(last_grant), 128'(5'b00100));
        step("stall_out", 5'b00000, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) step("stream", 5'b10000, 1'b0, 1'b1, 1'b0);
        step("stream_end", 5'b00000, 1'b0, 1'b1, 1'b0);

        step("clr_fill", 5'b01000, 1'b0, 1'b1, 1'b0);
        step("clr", 5'b00000, 1'b0, 1'b0, 1'b1);
        step("clr_after", 5'b00000, 1'b0, 1'b0, 1'b0);

        step("mrst_fill", 5'b00010, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst.out_valid", 128'(out_valid), 128'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("mrst_after", 5'b00000, 1'b0, 1'b1, 1'b0);

        first4 = -1;
        n4 = 0;
        for (int k = 1; k <= 40; k++) begin
            step("starve", 5'b10010, 1'b0, 1'b1, 1'b0);
            if (last_grant[4]) begin
                n4++;
                if (first4 < 0) first4 = k;
            end
        end
        chk("starve.first", 128'(first4), 128'(STARVE ? 16 : -1));
        chk("starve.count", 128'(n4), 128'(STARVE ? 2 : 0));
        step("starve_end", 5'b00000, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 600; i++) begin
            step("rand", 5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 29) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
